mem_access_unit: RTL and testbench

Memory-side responder for the multicycle processor's load/store/fetch traffic. It accepts one request at a time from the control unit and drives the synchronous data/instruction memory, absorbing the memory's fixed read latency. It also performs byte/halfword lane selection, sign/zero extension, read-modify-write for `sb`/`sh`, and alignment checking. It replaces the hand-counted wait states in the controller with a valid/ready request and a one-cycle completion pulse.

---
 rtl/mem_access_pkg.sv | 29 ++
 rtl/mem_lane_align.sv | 42 ++++
 rtl/mem_access_unit.sv | 163 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory access unit: access sizes, FSM states and
// the default memory read latency.
package mem_access_pkg;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;

    localparam int MEM_LAT_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_e;

    // Size 3 is reserved and behaves as a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offs);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = offs[0];
            default: mis = (offs != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts and extends load data, and merges
// sub-word store data into the old memory word.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offs,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;

    always_comb begin
        lane_b     = rdata[{offs, 3'b000} +: 8];
        lane_h     = offs[1] ? rdata[31:16] : rdata[15:0];
        load_data  = rdata;
        store_data = wdata;
        case (size)
            SZ_BYTE: begin
                load_data  = is_unsigned ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
                store_data = old_word;
                store_data[{offs, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data  = is_unsigned ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
                store_data = offs[1] ? {wdata[15:0], old_word[15:0]}
                                     : {old_word[31:16], wdata[15:0]};
            end
            default: begin
                load_data  = rdata;
                store_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-side responder: one load/store at a time, absorbs the memory read
// latency, performs lane selection/extension and read-modify-write stores.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misalign,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  offs_q, offs_d;
    logic [1:0]  size_q, size_d;
    logic        write_q, write_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_misalign_q, resp_misalign_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_wr_q, mem_wr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [31:0] load_data;
    logic [31:0] store_data;

    // The read data is consumed in the same cycle it is captured, so the
    // merged store word and the extended load value are registered directly.
    mem_lane_align u_align (
        .rdata       (mem_rdata),
        .old_word    (mem_rdata),
        .wdata       (wdata_q),
        .offs        (offs_q),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .load_data   (load_data),
        .store_data  (store_data)
    );

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        offs_d          = offs_q;
        size_d          = size_q;
        write_d         = write_q;
        unsigned_d      = unsigned_q;
        wdata_d         = wdata_q;
        resp_valid_d    = 1'b0;
        resp_rdata_d    = resp_rdata_q;
        resp_misalign_d = resp_misalign_q;
        mem_addr_d      = mem_addr_q;
        mem_wr_d        = 1'b0;
        mem_wdata_d     = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    offs_d     = req_addr[1:0];
                    size_d     = req_size;
                    write_d    = req_write;
                    unsigned_d = req_unsigned;
                    wdata_d    = req_wdata;
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        state_d         = ST_RESP;
                        resp_valid_d    = 1'b1;
                        resp_rdata_d    = 32'd0;
                        resp_misalign_d = 1'b1;
                    end else begin
                        mem_addr_d = {req_addr[31:2], 2'b00};
                        if (req_write && (req_size == SZ_WORD || req_size == 2'd3)) begin
                            state_d     = ST_WRITE;
                            mem_wr_d    = 1'b1;
                            mem_wdata_d = req_wdata;
                        end else begin
                            state_d = ST_READ;
                            cnt_d   = 3'(MEM_LAT);
                        end
                    end
                end
            end
            ST_READ: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    if (write_q) begin
                        state_d     = ST_WRITE;
                        mem_wr_d    = 1'b1;
                        mem_wdata_d = store_data;
                    end else begin
                        state_d         = ST_RESP;
                        resp_valid_d    = 1'b1;
                        resp_rdata_d    = load_data;
                        resp_misalign_d = 1'b0;
                    end
                end
            end
            ST_WRITE: begin
                state_d         = ST_RESP;
                resp_valid_d    = 1'b1;
                resp_rdata_d    = 32'd0;
                resp_misalign_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            cnt_q           <= 3'd0;
            offs_q          <= 2'd0;
            size_q          <= 2'd0;
            write_q         <= 1'b0;
            unsigned_q      <= 1'b0;
            wdata_q         <= 32'd0;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= 32'd0;
            resp_misalign_q <= 1'b0;
            mem_addr_q      <= 32'd0;
            mem_wr_q        <= 1'b0;
            mem_wdata_q     <= 32'd0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            offs_q          <= offs_d;
            size_q          <= size_d;
            write_q         <= write_d;
            unsigned_q      <= unsigned_d;
            wdata_q         <= wdata_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_misalign_q <= resp_misalign_d;
            mem_addr_q      <= mem_addr_d;
            mem_wr_q        <= mem_wr_d;
            mem_wdata_q     <= mem_wdata_d;
        end
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_misalign = resp_misalign_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wr        = mem_wr_q;
    assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random requests checked
// against a word-array reference model of the memory and access rules.
module tb_mem_access_unit;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misalign;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] dev_mem [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] rd_p;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_LAT(LAT)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_misalign (resp_misalign),
        .mem_addr      (mem_addr),
        .mem_wr        (mem_wr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    // Memory device: address-to-data latency of LAT cycles (LAT-1 register stages).
    always @(posedge clk) begin
        if (mem_wr) dev_mem[mem_addr[9:2]] <= mem_wdata;
        rd_p <= dev_mem[mem_addr[9:2]];
    end
    assign mem_rdata = rd_p;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h required %h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic bit ref_misaligned(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd2) return 1'b0;
        if (sz == 2'd1) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] a,
                                             input logic [1:0] sz, input logic u);
        logic [31:0] v;
        if (sz == 2'd2) begin
            v = (word >> (8 * (a % 4))) & 32'hFF;
            if (!u && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (!u && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] a,
                                              input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        if (sz == 2'd2) begin
            sh = 8 * (a % 4);
            mask = 32'hFF << sh;
        end else if (sz == 2'd1) begin
            sh = 16 * ((a / 2) % 2);
            mask = 32'hFFFF << sh;
        end else begin
            sh = 0;
            mask = 32'hFFFF_FFFF;
        end
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        dev_mem[a[9:2]] = w;
        ref_mem[a[9:2]] = w;
    endtask

    // Issues one request from IDLE (at a negedge) and checks the whole transaction.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] got_rdata, output logic [31:0] got_wdata);
        bit          mis;
        bit          sub_store;
        logic [31:0] old, exp_rd, exp_wd;
        int          exp_lat, exp_wrs, exp_wr_k;
        int          lat, wrs, wr_k;
        logic [31:0] wr_a;
        mis       = ref_misaligned(sz, a);
        sub_store = w && (sz == 2'd1 || sz == 2'd2);
        old       = ref_mem[a[9:2]];
        exp_rd    = (mis || w) ? 32'd0 : ref_load(old, a, sz, u);
        exp_wd    = ref_store(old, a, sz, wd);
        exp_lat   = mis ? 1 : (!w ? LAT + 1 : (sub_store ? LAT + 2 : 2));
        exp_wrs   = (w && !mis) ? 1 : 0;
        exp_wr_k  = exp_lat - 1;
        lat = 0; wrs = 0; wr_k = 0; wr_a = 32'd0; got_wdata = 32'd0;

        check("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (k == 1 && !mis) check("mem_addr_c1", mem_addr, {a[31:2], 2'b00});
            if (mem_wr) begin
                wrs++; wr_k = k; got_wdata = mem_wdata; wr_a = mem_addr;
            end
            if (resp_valid) begin
                lat = k;
                break;
            end
        end
        got_rdata = resp_rdata;
        check("resp_latency", lat, exp_lat);
        check("resp_misalign", {31'd0, resp_misalign}, {31'd0, mis});
        check("resp_rdata", resp_rdata, exp_rd);
        check("wr_count", wrs, exp_wrs);
        if (exp_wrs == 1) begin
            check("wr_cycle", wr_k, exp_wr_k);
            check("wr_data", got_wdata, exp_wd);
            check("wr_addr", wr_a, {a[31:2], 2'b00});
            ref_mem[a[9:2]] = exp_wd;
        end
        @(negedge clk);
        check("resp_pulse", {31'd0, resp_valid}, 32'd0);
        check("rdata_hold", resp_rdata, exp_rd);
    endtask

    logic [31:0] r, wdv;
    logic [31:0] ra, rd;
    int          wr_seen, resp_seen;

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < 256; i++) begin
            dev_mem[i] = $urandom;
            ref_mem[i] = dev_mem[i];
        end
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_misalign", {31'd0, resp_misalign}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        preload(32'h10, 32'h1234_5678);
        do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'd0, r, wdv);
        check("lw_value", r, 32'h1234_5678);

        preload(32'h10, 32'h80FF_0102);
        do_req(1'b0, 2'd2, 1'b0, 32'h13, 32'd0, r, wdv);
        check("lb_value", r, 32'hFFFF_FF80);
        do_req(1'b0, 2'd2, 1'b1, 32'h13, 32'd0, r, wdv);
        check("lbu_value", r, 32'h0000_0080);
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'd0, r, wdv);
        check("lh_value", r, 32'hFFFF_80FF);

        preload(32'h20, 32'h1111_2222);
        do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_BEEF, r, wdv);
        check("sh_wdata", wdv, 32'hBEEF_2222);

        do_req(1'b0, 2'd0, 1'b0, 32'h6, 32'd0, r, wdv);

        // Back-to-back word stores with req_valid held high throughout.
        wr_seen = 0;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'hA5A5_0001;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin req_addr = 32'h44; req_wdata = 32'h5A5A_0002; end
            if (k == 4) req_valid = 1'b0;
            check($sformatf("b2b_ready_c%0d", k), {31'd0, req_ready},
                  (k == 3 || k == 6) ? 32'd1 : 32'd0);
            check($sformatf("b2b_resp_c%0d", k), {31'd0, resp_valid},
                  (k == 2 || k == 5) ? 32'd1 : 32'd0);
            if (mem_wr) begin
                wr_seen++;
                check($sformatf("b2b_wdata_c%0d", k), mem_wdata,
                      (k == 1) ? 32'hA5A5_0001 : 32'h5A5A_0002);
            end
        end
        check("b2b_wr_count", wr_seen, 2);
        ref_mem[8'h10] = 32'hA5A5_0001;
        ref_mem[8'h11] = 32'h5A5A_0002;
        do_req(1'b0, 2'd0, 1'b0, 32'h44, 32'd0, r, wdv);

        // Reset while a sub-word store is still reading.
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h31; req_wdata = 32'h0000_00AA;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_busy", {31'd0, req_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wr_seen = 0; resp_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (mem_wr) wr_seen++;
            if (resp_valid) resp_seen++;
        end
        check("abort_no_wr", wr_seen, 0);
        check("abort_no_resp", resp_seen, 0);
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_mem_addr", mem_addr, 32'd0);

        for (int n = 0; n < 60; n++) begin
            ra = $urandom;
            rd = $urandom;
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), ra, rd, r, wdv);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
